// File: rtl/ula_display_ctrl_pkg.sv
// Shared types and constants for the ALU result display controller.
// Leading-zero blanking is enabled by defining DISPLAY_LZB_EN.
package ula_display_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StCommit
    } state_e;

    localparam logic BASE_OCT = 1'b0;
    localparam logic BASE_DEC = 1'b1;

    localparam logic [1:0] DIG_UN  = 2'd0;
    localparam logic [1:0] DIG_DEZ = 2'd1;
    localparam logic [1:0] DIG_CEN = 2'd2;

    localparam int unsigned BCD_ITERS = 8;

    typedef struct packed {
        logic [3:0] cen;
        logic [3:0] dez;
        logic [3:0] un;
    } digits_t;

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: converts an 8-bit value to 3 BCD digits,
// one shift-add-3 iteration per cycle, with a one-cycle done pulse.
module bin_to_bcd_seq
    import ula_display_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  value_i,
    output logic        done_o,
    output logic [11:0] bcd_o
);

    logic [7:0]  shift_q, shift_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic [11:0] adj;

    always_comb begin
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;
        adj      = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

        if (start_i && !active_q) begin
            shift_d  = value_i;
            bcd_d    = '0;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            // Top bit of the corrected accumulator is always 0 for inputs <= 255.
            {bcd_d, shift_d} = {adj[10:0], shift_q, 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(BCD_ITERS - 1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/ula_display_ctrl.sv
// ALU result display controller: octal/decimal conversion and a scanned
// shared-decoder output. Define DISPLAY_LZB_EN for leading-zero blanking.
module ula_display_ctrl
    import ula_display_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       result_valid,
    input  logic [7:0] result,
    input  logic       base_sel,
    output logic       result_ready,
    output logic       busy,
    output logic [3:0] digit_code,
    output logic [2:0] digit_en
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_e state_q, state_d;

    logic            accept;
    logic            conv_start;
    logic            conv_done;
    logic            commit;
    logic [11:0]     conv_bcd;

    logic [7:0]      shadow_res_q, shadow_res_d;
    logic            shadow_base_q, shadow_base_d;
    digits_t         disp_q, disp_d;
    digits_t         staged;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            wrap;
    logic [2:0]      en_q, en_d;
    logic [3:0]      code_q, code_d;
    logic            blank;

    assign accept = result_valid && result_ready;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (base_sel == BASE_DEC) ? StConvert : StCommit;
                end
            end
            StConvert: begin
                if (conv_done) begin
                    state_d = StCommit;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        result_ready = (state_q == StIdle);
        busy         = (state_q != StIdle);
        conv_start   = (state_q == StIdle) && result_valid && (base_sel == BASE_DEC);
        commit       = (state_q == StCommit);
    end

    bin_to_bcd_seq u_bin_to_bcd_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (conv_start),
        .value_i (result),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_comb begin
        shadow_res_d  = shadow_res_q;
        shadow_base_d = shadow_base_q;
        if (accept) begin
            shadow_res_d  = result;
            shadow_base_d = base_sel;
        end

        if (shadow_base_q == BASE_DEC) begin
            staged.cen = conv_bcd[11:8];
            staged.dez = conv_bcd[7:4];
            staged.un  = conv_bcd[3:0];
        end else begin
            staged.cen = {2'b00, shadow_res_q[7:6]};
            staged.dez = {1'b0, shadow_res_q[5:3]};
            staged.un  = {1'b0, shadow_res_q[2:0]};
        end

        // Displayed digits only change when the FSM leaves COMMIT.
        disp_d = commit ? staged : disp_q;
    end

    // Refresh scan, free-running regardless of the FSM.
    always_comb begin
        wrap  = (cnt_q == CntW'(REFRESH_DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + CntW'(1);
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == DIG_CEN) ? DIG_UN : idx_q + 2'd1;
        end
    end

    // Output registers are fed from next-state values so they track wrap and commit edges.
    always_comb begin
        en_d   = 3'b001;
        code_d = disp_d.un;
        blank  = 1'b0;
        case (idx_d)
            DIG_UN: begin
                en_d   = 3'b001;
                code_d = disp_d.un;
            end
            DIG_DEZ: begin
                en_d   = 3'b010;
                code_d = disp_d.dez;
            end
            DIG_CEN: begin
                en_d   = 3'b100;
                code_d = disp_d.cen;
            end
            default: begin
                en_d   = 3'b001;
                code_d = disp_d.un;
            end
        endcase
`ifdef DISPLAY_LZB_EN
        if ((idx_d == DIG_CEN) && (disp_d.cen == 4'd0)) begin
            blank = 1'b1;
        end
        if ((idx_d == DIG_DEZ) && (disp_d.cen == 4'd0) && (disp_d.dez == 4'd0)) begin
            blank = 1'b1;
        end
`else
        blank = 1'b0;
`endif
        if (blank) begin
            en_d   = 3'b000;
            code_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_res_q  <= '0;
            shadow_base_q <= BASE_OCT;
            disp_q        <= '0;
            cnt_q         <= '0;
            idx_q         <= DIG_UN;
            en_q          <= 3'b001;
            code_q        <= 4'd0;
        end else begin
            shadow_res_q  <= shadow_res_d;
            shadow_base_q <= shadow_base_d;
            disp_q        <= disp_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            en_q          <= en_d;
            code_q        <= code_d;
        end
    end

    assign digit_en   = en_q;
    assign digit_code = code_q;

endmodule

// File: tb/tb_ula_display_ctrl.sv
// Directed bench for ula_display_ctrl with REFRESH_DIV=4; expectations
// follow DISPLAY_LZB_EN when it is defined.
module tb_ula_display_ctrl;

    logic       clk;
    logic       rst_n;
    logic       result_valid;
    logic [7:0] result;
    logic       base_sel;
    logic       result_ready;
    logic       busy;
    logic [3:0] digit_code;
    logic [2:0] digit_en;

    int n_checks;
    int n_errors;

    ula_display_ctrl #(
        .REFRESH_DIV (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .result_valid (result_valid),
        .result       (result),
        .base_sel     (base_sel),
        .result_ready (result_ready),
        .busy         (busy),
        .digit_code   (digit_code),
        .digit_en     (digit_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Watch one full scan (12 cycles) and check the digit seen in each slot.
    // 5'h1F marks a slot that never showed up enabled.
    task automatic show_check(input string tag, input logic [4:0] eh, input logic [4:0] et,
                              input logic [4:0] eu, input int eblanks);
        logic [4:0] h, t, u;
        int blanks, bad;
        h = 5'h1F;
        t = 5'h1F;
        u = 5'h1F;
        blanks = 0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            case (digit_en)
                3'b001:  u = {1'b0, digit_code};
                3'b010:  t = {1'b0, digit_code};
                3'b100:  h = {1'b0, digit_code};
                3'b000:  if (digit_code == 4'd0) blanks++; else bad++;
                default: bad++;
            endcase
        end
        check({tag, "_hund"}, 32'(h), 32'(eh));
        check({tag, "_tens"}, 32'(t), 32'(et));
        check({tag, "_unit"}, 32'(u), 32'(eu));
        check({tag, "_blank"}, 32'(blanks), 32'(eblanks));
        check({tag, "_bad_slot"}, 32'(bad), 32'd0);
    endtask

    // Accept a decimal result and wait, bounded, for the FSM to return to idle.
    task automatic run_dec(input string tag, input logic [7:0] v);
        int n;
        result_valid = 1'b1;
        result       = v;
        base_sel     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_valid = 1'b0;
        n = 1;
        while (busy && n < 40) begin
            @(negedge clk);
            if (busy) n++;
        end
        check({tag, "_busy_len"}, 32'(n), 32'd10);
    endtask

    initial begin
        int nb;
        logic [3:0] exp_old;
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        result_valid = 1'b0;
        result       = 8'd0;
        base_sel     = 1'b0;

        #12;
        check("rst_en", 32'(digit_en), 32'h1);
        check("rst_code", 32'(digit_code), 32'h0);
        check("rst_ready", 32'(result_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clk);
            if ((k % 4 == 0) || (k % 4 == 3)) begin
                check("scan_rot", 32'(digit_en), 32'h1 << ((k / 4) % 3));
            end
        end

        // Octal 0xFF: 3,7,7 after one cycle with ready low.
        result_valid = 1'b1;
        result       = 8'hFF;
        base_sel     = 1'b0;
        check("oct_ready_pre", 32'(result_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        result_valid = 1'b0;
        check("oct_ready_low", 32'(result_ready), 32'h0);
        @(negedge clk);
        check("oct_ready_back", 32'(result_ready), 32'h1);
        show_check("oct_ff", 5'd3, 5'd7, 5'd7, 0);

        // Decimal 255; old octal digits stay while busy; a result offered mid-convert is dropped.
        result_valid = 1'b1;
        result       = 8'd255;
        base_sel     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_valid = 1'b0;
        nb = 0;
        while (busy && nb < 40) begin
            nb++;
            exp_old = (digit_en == 3'b100) ? 4'd3 : 4'd7;
            check("dec_hold_old", 32'(digit_code), 32'(exp_old));
            if (nb == 3) begin
                result_valid = 1'b1;
                result       = 8'd10;
                base_sel     = 1'b1;
            end
            if (nb == 5) result_valid = 1'b0;
            @(negedge clk);
        end
        check("dec255_busy_len", 32'(nb), 32'd10);
        check("dec255_ready", 32'(result_ready), 32'h1);
        @(negedge clk);
        check("no_queue_busy", 32'(busy), 32'h0);
        show_check("dec_255", 5'd2, 5'd5, 5'd5, 0);

        run_dec("dec10", 8'd10);
`ifdef DISPLAY_LZB_EN
        show_check("dec_010", 5'h1F, 5'd1, 5'd0, 4);
`else
        show_check("dec_010", 5'd0, 5'd1, 5'd0, 0);
`endif

        run_dec("dec7", 8'd7);
`ifdef DISPLAY_LZB_EN
        show_check("dec_007", 5'h1F, 5'h1F, 5'd7, 8);
`else
        show_check("dec_007", 5'd0, 5'd0, 5'd7, 0);
`endif

        run_dec("dec100", 8'd100);
        show_check("dec_100", 5'd1, 5'd0, 5'd0, 0);

        // Octal 0xAC = 8'o254.
        result_valid = 1'b1;
        result       = 8'hAC;
        base_sel     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        result_valid = 1'b0;
        show_check("oct_254", 5'd2, 5'd5, 5'd4, 0);

        // Reset during the 4th CONVERT cycle of 200.
        result_valid = 1'b1;
        result       = 8'd200;
        base_sel     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_en", 32'(digit_en), 32'h1);
        check("abort_code", 32'(digit_code), 32'h0);
        check("abort_ready", 32'(result_ready), 32'h1);
        check("abort_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_idle_busy", 32'(busy), 32'h0);
        check("abort_idle_ready", 32'(result_ready), 32'h1);
`ifdef DISPLAY_LZB_EN
        show_check("abort_digits", 5'h1F, 5'h1F, 5'd0, 8);
`else
        show_check("abort_digits", 5'd0, 5'd0, 5'd0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
